// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port of the multicycle MIPS core.
//
// Handshake: the core (master) raises mem_req together with mem_we, mem_addr
// and mem_wdata and holds all four stable until the memory (slave) answers
// with mem_ready=1 in a cycle where mem_req=1. The rising clock edge of that
// cycle completes the transfer and, for reads, samples mem_rdata. mem_ready
// carries no meaning while mem_req=0. mem_req falls the cycle after the
// accepting edge unless the next state issues another request at once.
interface mips_multicycle_core_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one shared memory port, PC/IR/MDR/A/B/ALUOut,
// 32x32 register file, memory-mapped PortIn/PortOut, jal/jr, and a terminal
// HALT state entered on any illegal opcode or funct.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC      = 32'h0040_0000,
   parameter int          PORT_IN_WIDTH = 8,
   parameter logic [31:0] PORT_ADDR     = 32'h1001_0024,
   parameter int          ADDR_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
   mips_multicycle_core_if.master   bus,
   output logic [31:0]              PortOut,
   output logic [31:0]              ALUResultOut,
   output logic                     halted,
   output logic [3:0]               state_dbg_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_IO       = 4'd7,
      S_WB_ALU   = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] port_out_q, port_out_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] regs_q [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] imm_sext, imm_zext, mem_ea;
   logic [31:0] alu_r, alu_i, addr_w;
   logic        ins_legal, mem_ack;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign imm      = ir_q[15:0];
   assign target   = ir_q[25:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};
   assign mem_ea   = a_q + imm_sext;
   // A transfer completes only on an edge where our own request is up.
   assign mem_ack  = mem_req_q & bus.mem_ready;

   // Decode legality of the instruction currently held in IR.
   always_comb begin
      ins_legal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_SLL, FN_SRL, FN_JR, FN_ADD,
               FN_SUB, FN_AND, FN_OR, FN_SLT: ins_legal = 1'b1;
               default:                      ins_legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
         OP_ORI, OP_LUI, OP_LW, OP_SW:       ins_legal = 1'b1;
         default:                            ins_legal = 1'b0;
      endcase
   end

   // ALU for R-type (A op B) and I-type (A op imm) results.
   always_comb begin
      alu_r = 32'h0;
      alu_i = 32'h0;
      case (funct)
         FN_ADD:  alu_r = a_q + b_q;
         FN_SUB:  alu_r = a_q - b_q;
         FN_AND:  alu_r = a_q & b_q;
         FN_OR:   alu_r = a_q | b_q;
         FN_SLT:  alu_r = {31'h0, $signed(a_q) < $signed(b_q)};
         FN_SLL:  alu_r = b_q << shamt;
         FN_SRL:  alu_r = b_q >> shamt;
         default: alu_r = 32'h0;
      endcase
      case (opcode)
         OP_ADDI: alu_i = a_q + imm_sext;
         OP_ORI:  alu_i = a_q | imm_zext;
         OP_LUI:  alu_i = {imm, 16'h0000};
         default: alu_i = 32'h0;
      endcase
   end

   // Next state and datapath register updates; everything holds by default.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mdr_d      = mdr_q;
      a_d        = a_q;
      b_d        = b_q;
      alu_d      = alu_q;
      port_out_d = port_out_q;
      rf_we      = 1'b0;
      rf_waddr   = rt;
      rf_wdata   = alu_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ack) begin
               ir_d    = bus.mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d   = regs_q[rs];
            b_d   = regs_q[rt];
            alu_d = pc_q + {imm_sext[29:0], 2'b00};
            if (!ins_legal) begin
               state_d = S_HALT;
            end else begin
               case (opcode)
                  OP_RTYPE:                state_d = S_EXEC_R;
                  OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                  OP_LW, OP_SW:            state_d = S_MEM_ADDR;
                  OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                  default:                 state_d = S_JUMP;
               endcase
            end
         end
         S_EXEC_R: begin
            alu_d = alu_r;
            if (funct == FN_JR) begin
               pc_d    = a_q;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB_ALU;
            end
         end
         S_EXEC_I: begin
            alu_d   = alu_i;
            state_d = S_WB_ALU;
         end
         S_MEM_ADDR: begin
            alu_d = mem_ea;
            if (mem_ea == PORT_ADDR)  state_d = S_IO;
            else if (opcode == OP_LW) state_d = S_MEM_RD;
            else                      state_d = S_MEM_WR;
         end
         S_MEM_RD: begin
            if (mem_ack) begin
               mdr_d   = bus.mem_rdata;
               state_d = S_WB_MEM;
            end
         end
         S_MEM_WR: begin
            if (mem_ack) state_d = S_FETCH;
         end
         S_IO: begin
            if (opcode == OP_LW) begin
               mdr_d   = 32'(PortIn);
               state_d = S_WB_MEM;
            end else begin
               port_out_d = b_q;
               state_d    = S_FETCH;
            end
         end
         S_WB_ALU: begin
            rf_we    = 1'b1;
            rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
            rf_wdata = alu_q;
            state_d  = S_FETCH;
         end
         S_WB_MEM: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            if ((a_q == b_q) ^ (opcode == OP_BNE)) pc_d = alu_q;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            // pc_q already points past the jal, which is the link value.
            pc_d = {pc_q[31:28], target, 2'b00};
            if (opcode == OP_JAL) begin
               rf_we    = 1'b1;
               rf_waddr = 5'd31;
               rf_wdata = pc_q;
            end
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Request/write strobes are registered from the state being entered, so a
   // request rises together with its state and back-to-back requests need no
   // idle cycle; after reset the first fetch request rises one edge later.
   always_comb begin
      mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      mem_we_d  = (state_d == S_MEM_WR);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Datapath registers and bus strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         mdr_q      <= 32'h0;
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         alu_q      <= 32'h0;
         port_out_q <= 32'h0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         mdr_q      <= mdr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         alu_q      <= alu_d;
         port_out_q <= port_out_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
      end
   end

   // Register file; $0 is never written so it always reads 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign addr_w        = (state_q == S_FETCH) ? pc_q : alu_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = ADDR_WIDTH'(addr_w);
   assign bus.mem_wdata = b_q;
   assign PortOut       = port_out_q;
   assign ALUResultOut  = alu_q;
   assign halted        = (state_q == S_HALT);
   assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: memory responder with configurable wait
// states, store scoreboard, fetch-trace checks for control flow and CPI.
module tb_mips_multicycle_core;

   localparam logic [31:0] RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] PORT_ADDR = 32'h1001_0024;
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
   localparam logic [3:0]  ST_FETCH  = 4'd0;
   localparam logic [3:0]  ST_DECODE = 4'd1;
   localparam logic [3:0]  ST_IO     = 4'd7;
   localparam logic [3:0]  ST_HALT   = 4'd12;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  port_in = 8'h00;
   logic [31:0] port_out, alu_result;
   logic        halted;
   logic [3:0]  state_dbg;

   always #5 clk = ~clk;

   mips_multicycle_core_if #(.ADDR_WIDTH(32)) mif ();

   mips_multicycle_core #(
      .RESET_PC(RESET_PC), .PORT_IN_WIDTH(8), .PORT_ADDR(PORT_ADDR), .ADDR_WIDTH(32)
   ) dut (
      .clk(clk), .reset(reset), .PortIn(port_in), .bus(mif),
      .PortOut(port_out), .ALUResultOut(alu_result), .halted(halted),
      .state_dbg_o(state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_miss = 0;
   logic [63:0] exp_q[$];
   logic [31:0] mem_arr [logic [31:0]];
   int          wait_cycles = 0;
   int          wait_cnt = 0;
   int          cyc = 0;
   int          n_writes = 0;
   int          n_exp_writes = 0;
   int          pidx = 0;
   bit          log_en = 1'b0;
   logic [31:0] f_addr_q[$];
   int          f_cyc_q[$];
   logic [31:0] exp_faddr_q[$];
   int          exp_fdelta_q[$];
   logic [31:0] hold_addr, hold_wdata;
   logic        hold_we;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin : mem_model
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (state_dbg == ST_IO) check("io_noreq", {31'h0, mif.mem_req}, 32'h0);
         if (mif.mem_req) begin
            if (wait_cnt == 0) begin
               hold_addr  = mif.mem_addr;
               hold_we    = mif.mem_we;
               hold_wdata = mif.mem_wdata;
            end else begin
               check("hold_addr", mif.mem_addr, hold_addr);
               check("hold_we", {31'h0, mif.mem_we}, {31'h0, hold_we});
               if (hold_we) check("hold_wdata", mif.mem_wdata, hold_wdata);
            end
            if (wait_cnt >= wait_cycles) begin
               mif.mem_ready = 1'b1;
               wait_cnt = 0;
               if (mif.mem_we) begin
                  mem_arr[mif.mem_addr] = mif.mem_wdata;
                  n_writes++;
                  if (exp_q.size() > 0) begin
                     logic [63:0] e;
                     e = exp_q.pop_front();
                     check("st_addr", mif.mem_addr, e[63:32]);
                     check("st_data", mif.mem_wdata, e[31:0]);
                  end
               end else begin
                  mif.mem_rdata = mem_arr.exists(mif.mem_addr) ? mem_arr[mif.mem_addr] : 32'h0;
                  if (log_en && state_dbg == ST_FETCH) begin
                     f_addr_q.push_back(mif.mem_addr);
                     f_cyc_q.push_back(cyc);
                  end
               end
            end else begin
               mif.mem_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            mif.mem_ready = (wait_cycles == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mif.mem_rdata = $urandom;
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic emit(input logic [31:0] w);
      mem_arr[RESET_PC + 32'(pidx * 4)] = w;
      pidx++;
   endtask

   task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
      n_exp_writes++;
   endtask

   task automatic check_reset_state();
      check("rst_req", {31'h0, mif.mem_req}, 32'h0);
      check("rst_we", {31'h0, mif.mem_we}, 32'h0);
      check("rst_portout", port_out, 32'h0);
      check("rst_aluout", alu_result, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_state", {28'h0, state_dbg}, {28'h0, ST_FETCH});
   endtask

   task automatic begin_test();
      reset = 1'b0;
      #1;
      check_reset_state();
      mem_arr.delete();
      exp_q.delete();
      f_addr_q.delete();
      f_cyc_q.delete();
      exp_faddr_q.delete();
      exp_fdelta_q.delete();
      pidx = 0;
      n_writes = 0;
      n_exp_writes = 0;
      log_en = 1'b0;
   endtask

   task automatic release_reset(input int waits);
      @(negedge clk);
      wait_cycles = waits;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_halt(input int budget);
      int k = 0;
      while (!halted && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("halt_reached", {31'h0, halted}, 32'h1);
   endtask

   task automatic finish_test();
      check("store_count", 32'(n_writes), 32'(n_exp_writes));
      check("sb_drained", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic check_fetch_log();
      check("fetch_cnt_ok", {31'h0, f_addr_q.size() >= exp_faddr_q.size()}, 32'h1);
      foreach (exp_faddr_q[i]) begin
         if (i < f_addr_q.size()) check("fetch_addr", f_addr_q[i], exp_faddr_q[i]);
         if (i > 0 && i < f_cyc_q.size())
            check("fetch_cpi", 32'(f_cyc_q[i] - f_cyc_q[i-1]), 32'(exp_fdelta_q[i-1]));
      end
   endtask

   // ---------------- tests ----------------
   initial begin : main
      // ALU program, zero-wait memory, with timing of the first 16 cycles.
      begin_test();
      emit(enc_i(6'h08, 5'd0, 5'd8, 16'h0005));          // addi $8,$0,5
      emit(enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD));          // addi $9,$0,-3
      emit(enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h20));       // add $10,$8,$9
      emit(enc_r(5'd9, 5'd8, 5'd11, 5'd0, 6'h2A));       // slt $11,$9,$8
      emit(enc_i(6'h0F, 5'd0, 5'd16, 16'h1001));         // lui $16,0x1001
      emit(enc_i(6'h2B, 5'd16, 5'd10, 16'h0000));        // sw $10,0($16)
      emit(enc_i(6'h2B, 5'd16, 5'd11, 16'h0004));        // sw $11,4($16)
      emit(enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h22));       // sub
      emit(enc_r(5'd8, 5'd9, 5'd13, 5'd0, 6'h24));       // and
      emit(enc_r(5'd8, 5'd9, 5'd14, 5'd0, 6'h25));       // or
      emit(enc_r(5'd0, 5'd8, 5'd15, 5'd4, 6'h00));       // sll $15,$8,4
      emit(enc_r(5'd0, 5'd9, 5'd17, 5'd28, 6'h02));      // srl $17,$9,28
      emit(enc_i(6'h0D, 5'd0, 5'd18, 16'h8001));         // ori $18,$0,0x8001
      emit(enc_r(5'd8, 5'd9, 5'd19, 5'd0, 6'h2A));       // slt $19,$8,$9
      emit(enc_i(6'h08, 5'd0, 5'd0, 16'h0009));          // addi $0,$0,9
      emit(enc_i(6'h2B, 5'd16, 5'd12, 16'h0040));
      emit(enc_i(6'h2B, 5'd16, 5'd13, 16'h0044));
      emit(enc_i(6'h2B, 5'd16, 5'd14, 16'h0048));
      emit(enc_i(6'h2B, 5'd16, 5'd15, 16'h004C));
      emit(enc_i(6'h2B, 5'd16, 5'd17, 16'h0050));
      emit(enc_i(6'h2B, 5'd16, 5'd18, 16'h0054));
      emit(enc_i(6'h2B, 5'd16, 5'd19, 16'h0058));
      emit(enc_i(6'h2B, 5'd16, 5'd0, 16'h005C));
      emit(HALT_WORD);
      expect_store(32'h1001_0000, 32'h0000_0002);
      expect_store(32'h1001_0004, 32'h0000_0001);
      expect_store(32'h1001_0040, 32'h0000_0008);
      expect_store(32'h1001_0044, 32'h0000_0005);
      expect_store(32'h1001_0048, 32'hFFFF_FFFD);
      expect_store(32'h1001_004C, 32'h0000_0050);
      expect_store(32'h1001_0050, 32'h0000_000F);
      expect_store(32'h1001_0054, 32'h0000_8001);
      expect_store(32'h1001_0058, 32'h0000_0000);
      expect_store(32'h1001_005C, 32'h0000_0000);
      release_reset(0);
      step(1);
      check("first_req", {31'h0, mif.mem_req}, 32'h1);
      check("first_addr", mif.mem_addr, RESET_PC);
      step(1);
      check("first_decode", {28'h0, state_dbg}, {28'h0, ST_DECODE});
      check("decode_noreq", {31'h0, mif.mem_req}, 32'h0);
      step(11);
      check("add_result", alu_result, 32'h0000_0002);
      step(4);
      check("slt_result", alu_result, 32'h0000_0001);
      check("t16_state", {28'h0, state_dbg}, {28'h0, ST_FETCH});
      check("t16_addr", mif.mem_addr, RESET_PC + 32'h10);
      wait_halt(400);
      finish_test();

      // Store then load through a memory with three wait cycles per request.
      begin_test();
      emit(enc_i(6'h0F, 5'd0, 5'd16, 16'h1001));         // lui $16,0x1001
      emit(enc_i(6'h0F, 5'd0, 5'd8, 16'hDEAD));          // lui $8,0xDEAD
      emit(enc_i(6'h0D, 5'd8, 5'd8, 16'hBEEF));          // ori $8,$8,0xBEEF
      emit(enc_i(6'h2B, 5'd16, 5'd8, 16'h0000));         // sw $8,0($16)
      emit(enc_i(6'h23, 5'd16, 5'd9, 16'h0000));         // lw $9,0($16)
      emit(enc_i(6'h2B, 5'd16, 5'd9, 16'h0008));         // sw $9,8($16)
      emit(HALT_WORD);
      expect_store(32'h1001_0000, 32'hDEAD_BEEF);
      expect_store(32'h1001_0008, 32'hDEAD_BEEF);
      release_reset(3);
      wait_halt(600);
      check("halt_noreq", {31'h0, mif.mem_req}, 32'h0);
      finish_test();

      // I/O port: load PortIn, store it to PortOut, no bus traffic for either.
      begin_test();
      port_in = 8'hA5;
      emit(enc_i(6'h0F, 5'd0, 5'd16, 16'h1001));         // lui $16,0x1001
      emit(enc_i(6'h23, 5'd16, 5'd8, 16'h0024));         // lw $8,0x24($16)
      emit(enc_i(6'h2B, 5'd16, 5'd8, 16'h0024));         // sw $8,0x24($16)
      emit(HALT_WORD);
      exp_faddr_q = '{RESET_PC, RESET_PC + 32'h4, RESET_PC + 32'h8, RESET_PC + 32'hC};
      exp_fdelta_q = '{4, 5, 4};
      log_en = 1'b1;
      release_reset(0);
      wait_halt(200);
      check("portout", port_out, 32'h0000_00A5);
      check_fetch_log();
      finish_test();

      // Control flow: bne fall-through, jal/jr round trip, beq self-loop.
      begin_test();
      emit(enc_i(6'h0F, 5'd0, 5'd16, 16'h1001));         // 00 lui $16,0x1001
      emit(enc_i(6'h08, 5'd0, 5'd8, 16'h0007));          // 04 addi $8,$0,7
      emit(enc_i(6'h08, 5'd0, 5'd9, 16'h0007));          // 08 addi $9,$0,7
      emit(enc_i(6'h05, 5'd8, 5'd9, 16'h0002));          // 0C bne $8,$9,+2
      emit({6'h03, 26'h010_0040});                       // 10 jal 0x00400100
      emit(enc_i(6'h2B, 5'd16, 5'd31, 16'h0000));        // 14 sw $31,0($16)
      emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));          // 18 beq $0,$0,-1
      mem_arr[RESET_PC + 32'h100] = enc_i(6'h08, 5'd0, 5'd10, 16'h0055);
      mem_arr[RESET_PC + 32'h104] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
      expect_store(32'h1001_0000, RESET_PC + 32'h14);
      exp_faddr_q = '{RESET_PC, RESET_PC + 32'h4, RESET_PC + 32'h8, RESET_PC + 32'hC,
                      RESET_PC + 32'h10, RESET_PC + 32'h100, RESET_PC + 32'h104,
                      RESET_PC + 32'h14, RESET_PC + 32'h18, RESET_PC + 32'h18,
                      RESET_PC + 32'h18};
      exp_fdelta_q = '{4, 4, 4, 3, 3, 4, 3, 4, 3, 3};
      log_en = 1'b1;
      release_reset(0);
      step(60);
      check("loop_not_halted", {31'h0, halted}, 32'h0);
      check_fetch_log();
      finish_test();

      // Illegal opcode halts one cycle after DECODE and stays off the bus.
      begin_test();
      emit(HALT_WORD);
      release_reset(2);
      wait_halt(20);
      check("halt_state", {28'h0, state_dbg}, {28'h0, ST_HALT});
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("halt_idle_req", {31'h0, mif.mem_req}, 32'h0);
      end
      begin_test();
      emit(HALT_WORD);
      release_reset(0);
      step(3);
      check("halt_edge3", {31'h0, halted}, 32'h1);
      check("halt_edge3_req", {31'h0, mif.mem_req}, 32'h0);

      // Reset asserted while a fetch is waiting on the memory.
      begin_test();
      emit(HALT_WORD);
      release_reset(5);
      step(3);
      #2;
      check("pend_req", {31'h0, mif.mem_req}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort_req", {31'h0, mif.mem_req}, 32'h0);
      check("abort_state", {28'h0, state_dbg}, {28'h0, ST_FETCH});
      release_reset(0);
      step(1);
      check("restart_req", {31'h0, mif.mem_req}, 32'h1);
      check("restart_addr", mif.mem_addr, RESET_PC);
      step(1);
      check("restart_decode", {28'h0, state_dbg}, {28'h0, ST_DECODE});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised successor to the single-cycle MIPS processor: a multi-cycle MIPS core with one shared instruction/data memory port and a variable-latency req/ready handshake.
- Holds its own PC, IR, MDR, A/B, ALUOut and 32x32 register file.
- One FSM sequences fetch, decode, execute, memory and write-back.
- Adds memory-mapped PortIn/PortOut, jal/jr, and halt-on-illegal-opcode, none of which the single-cycle core has.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- PORT_IN_WIDTH, 8, width of PortIn; zero-extended to 32 bits on read.
- PORT_ADDR, 32'h1001_0024, word address decoded as the I/O port. Loads read PortIn; stores write PortOut.
- ADDR_WIDTH, 32, width of mem_addr.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PortIn  in  PORT_IN_WIDTH  external input port.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1.
- mem_addr  out  ADDR_WIDTH  byte address, word aligned; stable while mem_req=1.
- mem_wdata  out  32  store data; stable while mem_req=1.
- PortOut  out  32  last value stored to PORT_ADDR.
- ALUResultOut  out  32  ALUOut register.
- halted  out  1  1 after an illegal opcode.

Behaviour:
- **Reset (async, reset=0):** all of the following reset to 0:
  - state=FETCH; PC=RESET_PC;
  - IR, MDR, A, B, ALUOut, all 32 registers;
  - PortOut, mem_req, mem_we, halted.
- **Instruction subset:**
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - I-type: addi 0x08, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02, jal 0x03.
  - Any other opcode or funct is illegal.
- **Arithmetic:** no overflow traps. addi/lw/sw sign-extend imm16; ori zero-extends; lui = imm<<16. slt is signed. Shift amount = shamt.
- **$zero:** writes to $0 are ignored; $0 always reads 0.
- **FSM transitions:**
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Wait until mem_ready, then IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rs, B<=rt; ALUOut<=PC+(sext(imm)<<2) (branch target). Illegal opcode -> HALT.
  - EXEC_R: ALUOut<=A op B. jr: PC<=A, go to FETCH. Otherwise go to WB_ALU.
  - EXEC_I: ALUOut<=A op imm, go to WB_ALU.
  - MEM_ADDR: ALUOut<=A+sext(imm). If address==PORT_ADDR, go to IO; else go to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: request held until mem_ready; MDR<=mem_rdata, go to WB_MEM.
  - MEM_WR: mem_we=1, mem_wdata=B; held until mem_ready, then go to FETCH.
  - IO: one cycle, no bus request. lw: MDR<=zext(PortIn), go to WB_MEM. sw: PortOut<=B, go to FETCH.
  - WB_ALU: rd (R-type) or rt (I-type) <= ALUOut, go to FETCH.
  - WB_MEM: rt<=MDR, go to FETCH.
  - BRANCH: one cycle. If (A==B) xor bne, PC<=ALUOut. Go to FETCH.
  - JUMP: PC<={PC[31:28], target, 2'b00}. jal also writes $31<=PC (already PC+4). Go to FETCH.
  - HALT: terminal. halted=1, mem_req=0; exits only on reset.
- **CPI:**
  - 3: beq, bne, j, jal, jr.
  - 4: R-type, I-type ALU, sw, I/O store.
  - 5: lw, I/O load.
  - Each memory wait cycle adds 1.
- **Handshake:**
  - mem_req may be asserted in the same cycle the state is entered.
  - mem_ready is ignored while mem_req=0.
  - mem_req deasserts the cycle after the accepting mem_ready. Back-to-back requests (e.g. MEM_WR then FETCH) insert no idle cycle unless a state requires one.
- **Reset mid-request:** mem_req drops immediately (async). No write is guaranteed to the memory.
- **PC:** wraps modulo 2^32.
- **Unaligned addresses:** no check; mem_addr[1:0] is passed through.

Test Plan:
- **Reset/fetch:** release reset; mem_ready=1 always -> first mem_addr=0x0040_0000; PC=0x0040_0004 after 2 edges.
- **ALU program:** addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1; slt $t3,$t1,$t0 -> $t2=2, $t3=1, ALUResultOut=1; 16 cycles with zero wait.
- **Memory with waits:** mem_ready delayed 3 cycles per request; sw then lw of 0xDEADBEEF at 0x1001_0000 -> lw returns 0xDEADBEEF; mem_req held steady with stable addr/we through the waits.
- **I/O:** PortIn=8'hA5; lw at PORT_ADDR, then sw of it to PORT_ADDR -> PortOut=0x0000_00A5; no mem_req issued during the IO states.
- **Control flow:**
  - beq taken with offset -1 -> loops to the same PC.
  - bne with equal operands -> falls through.
  - jal 0x0040_0100 -> $31=PC_jal+4.
  - jr $31 -> returns.
  - Branches/jumps take 3 cycles each.
- **Illegal/reset:** opcode 0x3F -> halted=1 in DECODE+1 and mem_req stays 0; reset pulsed low during a pending FETCH -> mem_req=0 at once and restart at RESET_PC.
